// File: rtl/lane_merge_rr.sv
// lane_merge_rr
// Merges two half-rate processing lanes back into one full-rate stream of
// operand pairs. The original order (lane0, lane1, lane0, ...) is restored.
// Each lane has a small FIFO, so a lane may run ahead of the output.
//
// Ports
//   clk_i, rst_i              clock (rising edge) and async active-high reset
//   l0_valid_i / l0_ready_o   lane0 push handshake, operands l0_op1_i/l0_op2_i
//   l1_valid_i / l1_ready_o   lane1 push handshake, operands l1_op1_i/l1_op2_i
//   out_valid_o / out_ready_i merged output handshake, operands out_op1_o/out_op2_o
//   out_lane_o                lane the current output item comes from (the turn)
//   merged_cnt_o              items delivered since reset, wraps modulo 2^CNT_W
module lane_merge_rr #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              l0_valid_i,
   output logic              l0_ready_o,
   input  logic [DATA_W-1:0] l0_op1_i,
   input  logic [DATA_W-1:0] l0_op2_i,
   input  logic              l1_valid_i,
   output logic              l1_ready_o,
   input  logic [DATA_W-1:0] l1_op1_i,
   input  logic [DATA_W-1:0] l1_op2_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_op1_o,
   output logic [DATA_W-1:0] out_op2_o,
   output logic              out_lane_o,
   output logic [CNT_W-1:0]  merged_cnt_o
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

   typedef enum logic {
      TURN0 = 1'b0,
      TURN1 = 1'b1
   } turn_e;

   // Storage: one entry holds {op1, op2}
   logic [2*DATA_W-1:0] mem_q [2][FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q [2];
   logic [PTR_W-1:0]  wr_ptr_d [2];
   logic [PTR_W-1:0]  rd_ptr_q [2];
   logic [PTR_W-1:0]  rd_ptr_d [2];
   logic [FCNT_W-1:0] count_q  [2];
   logic [FCNT_W-1:0] count_d  [2];
   turn_e             turn_q;
   logic [CNT_W-1:0]  merged_cnt_q;

   logic [2*DATA_W-1:0] in_data_s [2];
   logic [1:0]          in_valid_s;
   logic [1:0]          full_s;
   logic [1:0]          empty_s;
   logic [1:0]          lane_ready_s;
   logic [1:0]          push_s;
   logic [1:0]          pop_s;
   logic                turn_idx_s;
   logic                out_valid_s;
   logic                out_fire_s;
   logic [2*DATA_W-1:0] head_s;

   // Gather per-lane inputs into arrays and derive lane status / handshakes
   always_comb begin
      in_valid_s   = {l1_valid_i, l0_valid_i};
      in_data_s[0] = {l0_op1_i, l0_op2_i};
      in_data_s[1] = {l1_op1_i, l1_op2_i};
      turn_idx_s   = turn_q;
      for (int i = 0; i < 2; i++) begin
         full_s[i]  = (count_q[i] == FULL_CNT);
         empty_s[i] = (count_q[i] == {FCNT_W{1'b0}});
         // Readiness ignores pops, so a full lane refuses a push even while popping
         lane_ready_s[i] = !full_s[i] && !rst_i;
         push_s[i]       = in_valid_s[i] && lane_ready_s[i];
      end
      out_valid_s = !empty_s[turn_idx_s];
      out_fire_s  = out_valid_s && out_ready_i;
      pop_s[0]    = out_fire_s && (turn_q == TURN0);
      pop_s[1]    = out_fire_s && (turn_q == TURN1);
   end

   // Next-state for the lane FIFO pointers and occupancy counts
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         if (push_s[i]) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
         end else begin
            wr_ptr_d[i] = wr_ptr_q[i];
         end
         if (pop_s[i]) begin
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
         end else begin
            rd_ptr_d[i] = rd_ptr_q[i];
         end
         if (push_s[i] && !pop_s[i]) begin
            count_d[i] = count_q[i] + FCNT_W'(1);
         end else if (!push_s[i] && pop_s[i]) begin
            count_d[i] = count_q[i] - FCNT_W'(1);
         end else begin
            count_d[i] = count_q[i];
         end
      end
   end

   // FIFO storage write; contents are don't-care until pushed, so no reset
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 2; i++) begin
         if (push_s[i]) begin
            mem_q[i][wr_ptr_q[i]] <= in_data_s[i];
         end
      end
   end

   // FIFO pointer and count registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr_q[i] <= {PTR_W{1'b0}};
            rd_ptr_q[i] <= {PTR_W{1'b0}};
            count_q[i]  <= {FCNT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
      end
   end

   // Turn FSM: only an output transfer hands the turn to the other lane
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         turn_q <= TURN0;
      end else if (out_fire_s) begin
         case (turn_q)
            TURN0:   turn_q <= TURN1;
            TURN1:   turn_q <= TURN0;
            default: turn_q <= TURN0;
         endcase
      end
   end

   // Delivered-item counter, wraps naturally
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         merged_cnt_q <= {CNT_W{1'b0}};
      end else if (out_fire_s) begin
         merged_cnt_q <= merged_cnt_q + CNT_W'(1);
      end
   end

   // Output mux from registered FIFO state only; an empty turn lane reads as zero
   always_comb begin
      if (empty_s[turn_idx_s]) begin
         head_s = {(2*DATA_W){1'b0}};
      end else begin
         head_s = mem_q[turn_idx_s][rd_ptr_q[turn_idx_s]];
      end
   end

   assign l0_ready_o   = lane_ready_s[0];
   assign l1_ready_o   = lane_ready_s[1];
   assign out_valid_o  = out_valid_s;
   assign out_op1_o    = head_s[2*DATA_W-1:DATA_W];
   assign out_op2_o    = head_s[DATA_W-1:0];
   assign out_lane_o   = turn_idx_s;
   assign merged_cnt_o = merged_cnt_q;

endmodule
